// File: rtl/fifo_ctrl_pkg.sv
// Shared types and the round-robin pick helper for the FIFO write-side control.
package fifo_ctrl_pkg;

   // Widest supported producer count; the pick helper works on this width.
   localparam int MAX_REQ = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_BURST   = 2'd2,
      ST_RELEASE = 2'd3
   } state_e;

   // One-hot pick of the first set req starting at ptr and wrapping modulo n.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                  input logic [1:0]         ptr,
                                                  input int                 n);
      logic [MAX_REQ-1:0] g;
      logic               found;
      logic [1:0]         idx;
      g     = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_REQ; i++) begin
         idx = 2'((int'(ptr) + i) % n);
         if (i < n && !found && req[idx]) begin
            g[idx] = 1'b1;
            found  = 1'b1;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: one-hot winner among req, scanning from ptr.
module rr_arbiter
   import fifo_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [1:0]         ptr,
   output logic [NUM_REQ-1:0] gnt
);

   logic [MAX_REQ-1:0] req_ext;
   logic [MAX_REQ-1:0] pick;
   logic               unused_pick_hi;

   // Widen to the helper's fixed width, pick, then narrow back.
   always_comb begin
      req_ext              = '0;
      req_ext[NUM_REQ-1:0] = req;
      pick                 = rr_pick(req_ext, ptr, NUM_REQ);
      gnt                  = pick[NUM_REQ-1:0];
   end

   // Upper pick bits are always zero when fewer than MAX_REQ producers exist.
   assign unused_pick_hi = ^pick;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
   import fifo_ctrl_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int DATA_W    = 8,
   parameter int BURST_LEN = 16
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        valid_in,
   input  logic [NUM_REQ*DATA_W-1:0] wdata_in,
   input  logic                      almost_full,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        ready_out,
   output logic                      fifo_wr_en,
   output logic [DATA_W-1:0]         fifo_wdata,
   output logic                      busy
);

   localparam int               CNT_W     = $clog2(BURST_LEN + 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

   state_e              state_q, state_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d, pick;
   logic [1:0]          rr_ptr_q, rr_ptr_d, gnt_id;
   logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d, beat_inc;
   logic                fifo_wr_en_q, fifo_wr_en_d;
   logic [DATA_W-1:0]   fifo_wdata_q, fifo_wdata_d, sel_word;
   logic                accept, req_held;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req (req),
      .ptr (rr_ptr_q),
      .gnt (pick)
   );

   // Decode the granted producer's index and mux out its word.
   always_comb begin
      gnt_id   = '0;
      sel_word = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_q[i]) begin
            gnt_id   = 2'(i);
            sel_word = wdata_in[i*DATA_W +: DATA_W];
         end
      end
   end

   // almost_full kills ready in the same cycle so no new word enters the pipe.
   assign ready_out = (state_q == ST_BURST && !almost_full) ? gnt_q : '0;
   assign accept    = |(valid_in & ready_out);
   assign req_held  = |(req & gnt_q);
   assign beat_inc  = beat_cnt_q + CNT_W'(1);

   // Next-state, grant, pointer and write-port logic.
   // The grant clear and pointer advance are applied on the edge into RELEASE,
   // so both are already visible while the FSM sits in RELEASE.
   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      rr_ptr_d     = rr_ptr_q;
      beat_cnt_d   = beat_cnt_q;
      fifo_wr_en_d = 1'b0;
      fifo_wdata_d = fifo_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (|req && !almost_full) begin
               gnt_d      = pick;
               beat_cnt_d = '0;
               state_d    = ST_GRANT;
            end
         end
         ST_GRANT: state_d = ST_BURST;
         ST_BURST: begin
            if (accept) begin
               fifo_wr_en_d = 1'b1;
               fifo_wdata_d = sel_word;
               beat_cnt_d   = beat_inc;
            end
            if ((accept && beat_inc == BURST_MAX) || !req_held || almost_full) begin
               state_d  = ST_RELEASE;
               gnt_d    = '0;
               rr_ptr_d = (gnt_id == 2'(NUM_REQ - 1)) ? 2'd0 : gnt_id + 2'd1;
            end
         end
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset aborts any burst in flight.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= ST_IDLE;
         gnt_q        <= '0;
         rr_ptr_q     <= '0;
         beat_cnt_q   <= '0;
         fifo_wr_en_q <= 1'b0;
         fifo_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         rr_ptr_q     <= rr_ptr_d;
         beat_cnt_q   <= beat_cnt_d;
         fifo_wr_en_q <= fifo_wr_en_d;
         fifo_wdata_q <= fifo_wdata_d;
      end
   end

   assign gnt        = gnt_q;
   assign fifo_wr_en = fifo_wr_en_q;
   assign fifo_wdata = fifo_wdata_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=2, DATA_W=8, BURST_LEN=16).
module tb_fifo_wr_arbiter;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [1:0]  req = 2'b11, vld_en = 2'b00, valid_in, gnt, ready_out;
   logic [15:0] wdata_in;
   logic        almost_full = 1'b0, fifo_wr_en, busy;
   logic [7:0]  fifo_wdata, base0 = 8'd0, base1 = 8'd0;
   logic        cnt_clr = 1'b1;
   int          acc0 = 0, acc1 = 0, lim0 = 0, lim1 = 0;
   int          cyc = 0, errors = 0, checks = 0, onehot_bad = 0;
   int          mw = 0, mg = 0;
   logic [7:0]  wr_data[$];
   int          wr_cyc[$];
   logic [1:0]  gnt_seq[$];
   logic [1:0]  gnt_prev = 2'b00;

   always #5 sys_clk = ~sys_clk;

   fifo_wr_arbiter #(.NUM_REQ(2), .DATA_W(8), .BURST_LEN(16)) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .req         (req),
      .valid_in    (valid_in),
      .wdata_in    (wdata_in),
      .almost_full (almost_full),
      .gnt         (gnt),
      .ready_out   (ready_out),
      .fifo_wr_en  (fifo_wr_en),
      .fifo_wdata  (fifo_wdata),
      .busy        (busy)
   );

   // Producer model: each producer offers base + (words accepted so far), up to lim.
   always_comb begin
      valid_in[0] = vld_en[0] && (acc0 < lim0);
      valid_in[1] = vld_en[1] && (acc1 < lim1);
      wdata_in    = {base1 + 8'(acc1), base0 + 8'(acc0)};
   end

   always @(posedge sys_clk) begin
      cyc <= cyc + 1;
      if (cnt_clr) begin
         acc0 <= 0;
         acc1 <= 0;
      end else begin
         if (valid_in[0] && ready_out[0]) acc0 <= acc0 + 1;
         if (valid_in[1] && ready_out[1]) acc1 <= acc1 + 1;
      end
   end

   // Log writes and new grants away from the active edge.
   always @(negedge sys_clk) begin
      if (fifo_wr_en === 1'b1) begin
         wr_data.push_back(fifo_wdata);
         wr_cyc.push_back(cyc);
      end
      if (gnt !== gnt_prev && gnt !== 2'b00) gnt_seq.push_back(gnt);
      if ($isunknown(gnt) || $countones(gnt) > 1) onehot_bad <= onehot_bad + 1;
      gnt_prev <= gnt;
   end

   task automatic step(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic apply_reset();
      sys_rst = 1'b1; req = 2'b00; vld_en = 2'b00; almost_full = 1'b0; cnt_clr = 1'b1;
      step(2);
      sys_rst = 1'b0; cnt_clr = 1'b0;
      mw = wr_data.size();
      mg = gnt_seq.size();
   endtask

   task automatic test_reset();
      sys_rst = 1'b1; req = 2'b11; vld_en = 2'b11; lim0 = 100; lim1 = 100;
      step(3);
      checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt); end
      checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
      checks++; if (fifo_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h want 00", fifo_wdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (ready_out !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", ready_out); end
   endtask

   task automatic test_single_producer();
      apply_reset();
      base0 = 8'd1; lim0 = 20; req = 2'b01; vld_en = 2'b01;
      step(1);
      checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b want 01", gnt); end
      checks++; if (ready_out !== 2'b00) begin errors++; $display("FAIL single_ready_grant: got %b want 00", ready_out); end
      step(1);
      checks++; if (ready_out !== 2'b01) begin errors++; $display("FAIL single_ready_burst: got %b want 01", ready_out); end
      for (int i = 0; i < 100 && (wr_data.size() - mw) < 20; i++) step(1);
      checks++; if (wr_data.size() - mw != 20) begin errors++; $display("FAIL single_count: got %0d want 20", wr_data.size() - mw); end
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (wr_data[mw+i] !== 8'(i + 1)) begin errors++; $display("FAIL single_word%0d: got %h want %h", i, wr_data[mw+i], 8'(i + 1)); end
      end
      checks++; if (wr_cyc[mw+15] - wr_cyc[mw] != 15) begin errors++; $display("FAIL single_b2b: got %0d want 15", wr_cyc[mw+15] - wr_cyc[mw]); end
      checks++; if (wr_cyc[mw+16] - wr_cyc[mw+15] != 4) begin errors++; $display("FAIL single_gap: got %0d want 4", wr_cyc[mw+16] - wr_cyc[mw+15]); end
      checks++; if (gnt_seq.size() - mg != 2) begin errors++; $display("FAIL single_grants: got %0d want 2", gnt_seq.size() - mg); end
      checks++; if (gnt_seq[mg+1] !== 2'b01) begin errors++; $display("FAIL single_regrant: got %b want 01", gnt_seq[mg+1]); end
      req = 2'b00; vld_en = 2'b00;
      step(4);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", busy); end
   endtask

   task automatic test_fairness();
      logic [7:0] exp;
      apply_reset();
      base0 = 8'h00; base1 = 8'h80; lim0 = 100; lim1 = 100; req = 2'b11; vld_en = 2'b11;
      for (int i = 0; i < 200 && (wr_data.size() - mw) < 64; i++) step(1);
      for (int b = 0; b < 4; b++) begin
         checks++;
         if (gnt_seq[mg+b] !== ((b % 2 == 0) ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL fair_grant%0d: got %b want %b", b, gnt_seq[mg+b], (b % 2 == 0) ? 2'b01 : 2'b10);
         end
      end
      for (int w = 0; w < 64; w++) begin
         exp = 8'((((w / 16) % 2) * 128) + (w / 32) * 16 + (w % 16));
         checks++;
         if (wr_data[mw+w] !== exp) begin errors++; $display("FAIL fair_word%0d: got %h want %h", w, wr_data[mw+w], exp); end
      end
      for (int b = 1; b < 4; b++) begin
         checks++;
         if (wr_cyc[mw+16*b] - wr_cyc[mw+16*b-1] != 4) begin
            errors++; $display("FAIL fair_gap%0d: got %0d want 4", b, wr_cyc[mw+16*b] - wr_cyc[mw+16*b-1]);
         end
      end
      req = 2'b00; vld_en = 2'b00;
      step(4);
   endtask

   task automatic test_backpressure();
      apply_reset();
      base0 = 8'h40; lim0 = 100; req = 2'b01; vld_en = 2'b01;
      for (int i = 0; i < 40 && acc0 < 5; i++) step(1);
      almost_full = 1'b1;
      #1;
      checks++; if (ready_out !== 2'b00) begin errors++; $display("FAIL bp_ready_drop: got %b want 00", ready_out); end
      step(12);
      checks++; if (wr_data.size() - mw != 5) begin errors++; $display("FAIL bp_count: got %0d want 5", wr_data.size() - mw); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (wr_data[mw+i] !== 8'(8'h40 + i)) begin errors++; $display("FAIL bp_word%0d: got %h want %h", i, wr_data[mw+i], 8'(8'h40 + i)); end
      end
      checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL bp_no_grant: got %b want 00", gnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy: got %b want 0", busy); end
      checks++; if (gnt_seq.size() - mg != 1) begin errors++; $display("FAIL bp_grants: got %0d want 1", gnt_seq.size() - mg); end
      almost_full = 1'b0;
      step(1);
      checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL bp_regrant: got %b want 01", gnt); end
      req = 2'b00; vld_en = 2'b00;
      step(5);
   endtask

   task automatic test_early_drop();
      apply_reset();
      base1 = 8'h60; lim1 = 3; req = 2'b10; vld_en = 2'b10;
      for (int i = 0; i < 40 && acc1 < 2; i++) step(1);
      req = 2'b00;
      step(1);
      checks++; if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL drop_last_write: got %b want 1", fifo_wr_en); end
      checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL drop_release: got %b want 00", gnt); end
      req = 2'b11; vld_en = 2'b00;
      step(6);
      checks++; if (wr_data.size() - mw != 3) begin errors++; $display("FAIL drop_count: got %0d want 3", wr_data.size() - mw); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (wr_data[mw+i] !== 8'(8'h60 + i)) begin errors++; $display("FAIL drop_word%0d: got %h want %h", i, wr_data[mw+i], 8'(8'h60 + i)); end
      end
      checks++; if (gnt_seq[mg] !== 2'b10) begin errors++; $display("FAIL drop_first: got %b want 10", gnt_seq[mg]); end
      checks++; if (gnt_seq[mg+1] !== 2'b01) begin errors++; $display("FAIL drop_next: got %b want 01", gnt_seq[mg+1]); end
      req = 2'b00;
      step(4);
   endtask

   task automatic test_reset_mid_burst();
      apply_reset();
      base0 = 8'h20; base1 = 8'hA0; lim0 = 100; lim1 = 100; req = 2'b11; vld_en = 2'b11;
      for (int i = 0; i < 120 && !((gnt_seq.size() - mg) >= 2 && acc1 >= 4); i++) step(1);
      checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL mid_in_burst1: got %b want 10", gnt); end
      sys_rst = 1'b1;
      step(1);
      checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL mid_gnt: got %b want 00", gnt); end
      checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL mid_wr_en: got %b want 0", fifo_wr_en); end
      checks++; if (fifo_wdata !== 8'h00) begin errors++; $display("FAIL mid_wdata: got %h want 00", fifo_wdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
      sys_rst = 1'b0;
      mg = gnt_seq.size();
      step(4);
      checks++; if (gnt_seq[mg] !== 2'b01) begin errors++; $display("FAIL mid_restart: got %b want 01", gnt_seq[mg]); end
      req = 2'b00; vld_en = 2'b00;
      step(4);
   endtask

   initial begin
      test_reset();
      test_single_producer();
      test_fairness();
      test_backpressure();
      test_early_drop();
      test_reset_mid_burst();
      checks++; if (onehot_bad != 0) begin errors++; $display("FAIL gnt_onehot: got %0d bad cycles want 0", onehot_bad); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
